// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch stage.
package fetch_pkg;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_HALT} state_e;

  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 21;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;
  localparam int PC_INC  = 4;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch bundle: imem request/response, decode handoff and branch redirect.
interface instr_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 64
);
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [OPC_W-1:0]   if_opcode;
  logic [ADDR_W-1:0]  if_pc;
  logic               br_taken;
  logic [ADDR_W-1:0]  br_target;
  logic               fetch_fault;

  modport master (
    output imem_req_valid, imem_addr, if_valid, if_instr, if_opcode, if_pc, fetch_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready, br_taken, br_target
  );

  modport slave (
    input  imem_req_valid, imem_addr, if_valid, if_instr, if_opcode, if_pc, fetch_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready, br_taken, br_target
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// PC register: sequential +4 advance, branch redirect, misaligned-target fault.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] target,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] pc_q,
  output logic              fault,
  output logic              misaligned
);
  assign misaligned = redirect && (target[1:0] != 2'b00);

  // Advance is relative to the PC of the returned fetch, not pc_q; wraps mod 2^ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      fault <= 1'b0;
    end else if (redirect) begin
      if (misaligned) fault <= 1'b1;
      else            pc_q  <= target;
    end else if (advance) begin
      pc_q <= base + ADDR_W'(PC_INC);
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// LEGv8 fetch stage: one outstanding imem request, single-entry output register to decode.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master bus
);
  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, req_pc_q, out_pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q, fault, misaligned;
  logic               redirect, out_free, req_valid, hs, load;

  assign redirect  = bus.br_taken && (state_q != S_HALT);
  assign out_free  = !valid_q || bus.if_ready;
  assign req_valid = (state_q == S_REQ) && out_free;
  assign hs        = req_valid && bus.imem_req_ready;
  assign load      = (state_q == S_WAIT) && bus.imem_rsp_valid && !redirect;

  fetch_pc_gen #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .redirect   (redirect),
    .target     (bus.br_target),
    .advance    (load),
    .base       (req_pc_q),
    .pc_q       (pc_q),
    .fault      (fault),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // A redirect with a request still in flight must swallow that response (S_DRAIN).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ:   if (redirect)    state_d = hs ? S_DRAIN : S_REQ;
               else if (hs)     state_d = S_WAIT;
      S_WAIT:  if (redirect)    state_d = bus.imem_rsp_valid ? S_REQ : S_DRAIN;
               else if (bus.imem_rsp_valid) state_d = S_REQ;
      S_DRAIN: if (bus.imem_rsp_valid) state_d = S_REQ;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    if (misaligned) state_d = S_HALT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_pc_q <= '0;
    else if (hs) req_pc_q <= pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      instr_q  <= '0;
      out_pc_q <= '0;
    end else if (redirect) begin
      valid_q <= 1'b0;
      if (misaligned) begin
        instr_q  <= '0;
        out_pc_q <= '0;
      end
    end else if (load) begin
      valid_q  <= 1'b1;
      instr_q  <= bus.imem_rsp_data;
      out_pc_q <= req_pc_q;
    end else if (valid_q && bus.if_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = req_valid ? pc_q : '0;
  assign bus.if_valid       = valid_q;
  assign bus.if_instr       = instr_q;
  assign bus.if_opcode      = opcode_of(instr_q);
  assign bus.if_pc          = out_pc_q;
  assign bus.fetch_fault    = fault;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequencing, stall, redirects, fault, PC wrap.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total = 0;
  int lat = 1;

  instr_fetch_unit_if #(.ADDR_W(64)) bus ();
  instr_fetch_unit_if #(.ADDR_W(64)) bus2 ();

  instr_fetch_unit #(.ADDR_W(64), .RESET_PC(64'h100)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  instr_fetch_unit #(.ADDR_W(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  // addr[9] set -> ADD (opcode 11'h458), else LDUR (opcode 11'h7C2); low bits tag the address
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a[9]) return 32'h8B00_0000 | {16'h0, a[15:0]};
    return 32'hF840_0000 | {16'h0, a[15:0]};
  endfunction

  logic        pend;
  logic [63:0] pend_addr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.imem_rsp_valid <= 1'b0;
      bus.imem_rsp_data  <= '0;
      pend               <= 1'b0;
      pend_addr          <= '0;
    end else begin
      bus.imem_rsp_valid <= 1'b0;
      if (pend) begin
        bus.imem_rsp_valid <= 1'b1;
        bus.imem_rsp_data  <= mem_word(pend_addr);
        pend               <= 1'b0;
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        if (lat == 1) begin
          bus.imem_rsp_valid <= 1'b1;
          bus.imem_rsp_data  <= mem_word(bus.imem_addr);
        end else begin
          pend      <= 1'b1;
          pend_addr <= bus.imem_addr;
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus2.imem_rsp_valid <= 1'b0;
      bus2.imem_rsp_data  <= '0;
    end else begin
      bus2.imem_rsp_valid <= bus2.imem_req_valid && bus2.imem_req_ready;
      bus2.imem_rsp_data  <= mem_word(bus2.imem_addr);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_valid(output bit ok, output int n);
    ok = 1'b0;
    n = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      n++;
      if (bus.if_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.imem_req_ready = 1'b1; bus.if_ready = 1'b1;
    bus.br_taken = 1'b0; bus.br_target = '0;
    bus2.imem_req_ready = 1'b1; bus2.if_ready = 1'b1;
    bus2.br_taken = 1'b0; bus2.br_target = '0;
    lat = 1;
    repeat (3) @(negedge clk);
    total++; if (bus.imem_req_valid !== 1'b0) $display("FAIL rst_req_valid got %b want 0", bus.imem_req_valid); else pass_cnt++;
    total++; if (bus.imem_addr !== 64'h0) $display("FAIL rst_addr got %h want 0", bus.imem_addr); else pass_cnt++;
    total++; if (bus.if_valid !== 1'b0) $display("FAIL rst_if_valid got %b want 0", bus.if_valid); else pass_cnt++;
    total++; if (bus.if_instr !== 32'h0) $display("FAIL rst_if_instr got %h want 0", bus.if_instr); else pass_cnt++;
    total++; if (bus.if_pc !== 64'h0) $display("FAIL rst_if_pc got %h want 0", bus.if_pc); else pass_cnt++;
    total++; if (bus.fetch_fault !== 1'b0) $display("FAIL rst_fault got %b want 0", bus.fetch_fault); else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total++; if (bus.imem_req_valid !== 1'b0) $display("FAIL idle_req_valid got %b want 0", bus.imem_req_valid); else pass_cnt++;
    @(negedge clk);
    total++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 64'h100)
      $display("FAIL first_req got valid=%b addr=%h want 1/100", bus.imem_req_valid, bus.imem_addr); else pass_cnt++;
  endtask

  task automatic test_sequence();
    bit ok; int n;
    wait_valid(ok, n);
    total++; if (!ok || bus.if_pc !== 64'h100) $display("FAIL seq_pc0 got ok=%b pc=%h want 100", ok, bus.if_pc); else pass_cnt++;
    total++; if (bus.if_instr !== 32'hF840_0100) $display("FAIL seq_instr0 got %h want f8400100", bus.if_instr); else pass_cnt++;
    total++; if (bus.if_opcode !== 11'h7C2) $display("FAIL seq_opcode0 got %h want 7c2", bus.if_opcode); else pass_cnt++;
    wait_valid(ok, n);
    total++; if (!ok || bus.if_pc !== 64'h104) $display("FAIL seq_pc1 got ok=%b pc=%h want 104", ok, bus.if_pc); else pass_cnt++;
    wait_valid(ok, n);
    total++; if (!ok || bus.if_pc !== 64'h108) $display("FAIL seq_pc2 got ok=%b pc=%h want 108", ok, bus.if_pc); else pass_cnt++;
    total++; if (n !== 2) $display("FAIL seq_throughput got %0d cycles want 2", n); else pass_cnt++;
  endtask

  task automatic test_stall();
    bit ok; int n; bit unstable, req_seen;
    logic [31:0] hold_instr;
    logic [63:0] hold_pc;
    bus.if_ready = 1'b0;
    hold_instr = bus.if_instr;
    hold_pc = bus.if_pc;
    unstable = 1'b0; req_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!bus.if_valid || bus.if_instr !== hold_instr || bus.if_pc !== hold_pc) unstable = 1'b1;
      if (bus.imem_req_valid) req_seen = 1'b1;
    end
    total++; if (unstable || hold_pc !== 64'h108) $display("FAIL stall_hold got unstable=%b pc=%h want 0/108", unstable, hold_pc); else pass_cnt++;
    total++; if (req_seen) $display("FAIL stall_no_req got req=%b want 0", req_seen); else pass_cnt++;
    bus.if_ready = 1'b1;
    #1;
    total++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 64'h10C)
      $display("FAIL stall_release_req got valid=%b addr=%h want 1/10c", bus.imem_req_valid, bus.imem_addr); else pass_cnt++;
    wait_valid(ok, n);
    total++; if (!ok || bus.if_pc !== 64'h10C) $display("FAIL stall_next_pc got ok=%b pc=%h want 10c", ok, bus.if_pc); else pass_cnt++;
  endtask

  task automatic test_br_wait();
    bit ok; int n; bit found;
    lat = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.imem_req_valid && bus.imem_req_ready) found = 1'b1;
    end
    @(negedge clk);
    bus.br_taken = 1'b1; bus.br_target = 64'h200;
    @(negedge clk);
    bus.br_taken = 1'b0;
    total++; if (!found || bus.imem_req_valid !== 1'b0 || bus.if_valid !== 1'b0)
      $display("FAIL brw_drain got found=%b req=%b valid=%b want 1/0/0", found, bus.imem_req_valid, bus.if_valid); else pass_cnt++;
    wait_valid(ok, n);
    total++; if (!ok || bus.if_pc !== 64'h200) $display("FAIL brw_pc got ok=%b pc=%h want 200", ok, bus.if_pc); else pass_cnt++;
    total++; if (bus.if_instr !== 32'h8B00_0200 || bus.if_opcode !== 11'h458)
      $display("FAIL brw_instr got %h/%h want 8b000200/458", bus.if_instr, bus.if_opcode); else pass_cnt++;
  endtask

  task automatic test_br_handshake();
    bit ok; int n; bit stale;
    lat = 1;
    bus.br_taken = 1'b1; bus.br_target = 64'h100;
    @(negedge clk);
    bus.br_taken = 1'b0;
    wait_valid(ok, n);
    total++; if (!ok || bus.if_pc !== 64'h100) $display("FAIL brh_restart got ok=%b pc=%h want 100", ok, bus.if_pc); else pass_cnt++;
    total++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 64'h104)
      $display("FAIL brh_req104 got valid=%b addr=%h want 1/104", bus.imem_req_valid, bus.imem_addr); else pass_cnt++;
    bus.br_taken = 1'b1; bus.br_target = 64'h300;
    @(negedge clk);
    bus.br_taken = 1'b0;
    total++; if (bus.imem_req_valid !== 1'b0) $display("FAIL brh_drain_req got %b want 0", bus.imem_req_valid); else pass_cnt++;
    stale = 1'b0;
    wait_valid(ok, n);
    if (bus.if_pc === 64'h104) stale = 1'b1;
    total++; if (!ok || bus.if_pc !== 64'h300 || bus.if_instr !== 32'h8B00_0300)
      $display("FAIL brh_target got ok=%b pc=%h instr=%h want 300/8b000300", ok, bus.if_pc, bus.if_instr); else pass_cnt++;
    wait_valid(ok, n);
    if (bus.if_pc === 64'h104) stale = 1'b1;
    total++; if (!ok || stale || bus.if_pc !== 64'h304)
      $display("FAIL brh_no_stale got ok=%b stale=%b pc=%h want 1/0/304", ok, stale, bus.if_pc); else pass_cnt++;
  endtask

  task automatic test_fault();
    bit ok; int n; bit bad;
    bus.br_taken = 1'b1; bus.br_target = 64'h202;
    @(negedge clk);
    bus.br_taken = 1'b0;
    total++; if (bus.fetch_fault !== 1'b1 || bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b0 || bus.if_pc !== 64'h0)
      $display("FAIL flt_enter got fault=%b valid=%b req=%b pc=%h want 1/0/0/0",
               bus.fetch_fault, bus.if_valid, bus.imem_req_valid, bus.if_pc); else pass_cnt++;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.br_taken = (i == 5);
      bus.br_target = 64'h400;
      @(negedge clk);
      if (bus.imem_req_valid || bus.if_valid || !bus.fetch_fault || bus.imem_addr !== 64'h0) bad = 1'b1;
    end
    bus.br_taken = 1'b0;
    total++; if (bad) $display("FAIL flt_halt got activity=%b want 0", bad); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total++; if (bus.fetch_fault !== 1'b0) $display("FAIL flt_clear got %b want 0", bus.fetch_fault); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(ok, n);
    total++; if (!ok || bus.if_pc !== 64'h100) $display("FAIL flt_resume got ok=%b pc=%h want 100", ok, bus.if_pc); else pass_cnt++;
  endtask

  task automatic test_wrap();
    bit found;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus2.imem_req_valid) found = 1'b1;
    end
    total++; if (!found || bus2.imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC)
      $display("FAIL wrap_first got found=%b addr=%h want fffffffffffffffc", found, bus2.imem_addr); else pass_cnt++;
    @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus2.imem_req_valid) found = 1'b1;
    end
    total++; if (!found || bus2.imem_addr !== 64'h0) $display("FAIL wrap_second got found=%b addr=%h want 0", found, bus2.imem_addr); else pass_cnt++;
    total++; if (bus2.if_pc !== 64'hFFFF_FFFF_FFFF_FFFC || bus2.if_instr !== 32'h8B00_FFFC)
      $display("FAIL wrap_out got pc=%h instr=%h want fffffffffffffffc/8b00fffc", bus2.if_pc, bus2.if_instr); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_br_wait();
    test_br_handshake();
    test_fault();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
